// File: rtl/nios_system_sram_ctrl_if.sv
// nios_system_sram_ctrl_if: Avalon-MM bus between the Nios interconnect and the SRAM controller
interface nios_system_sram_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;
    modport master (output address, chipselect, read, write, writedata, input readdata, waitrequest);
    modport slave  (input address, chipselect, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/nios_system_sram_ctrl.sv
// nios_system_sram_ctrl: sequences single-word Avalon-MM reads/writes onto an async SRAM with programmable wait states
module nios_system_sram_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios_system_sram_ctrl_if.slave bus,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [DATA_W-1:0]     sram_dq_in,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);
    localparam int MAX_WAIT = RD_WAIT > WR_WAIT ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              req;
    assign req             = bus.chipselect & (bus.read | bus.write);
    assign bus.waitrequest = req & ~ack;
    assign bus.readdata    = rdata;
    // strobes are set on the edge that enters each state, so every pin is a flop output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ack         <= 1'b0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req) begin
                    sram_addr   <= bus.address;
                    sram_dq_out <= bus.writedata;
                    sram_ce_n   <= 1'b0;
                    if (bus.write) begin
                        state      <= WR_SETUP;
                        sram_dq_oe <= 1'b1;
                    end else begin
                        state     <= RD;
                        sram_oe_n <= 1'b0;
                        cnt       <= CNT_W'(RD_WAIT - 1);
                    end
                end
                RD: if (cnt == '0) begin
                    rdata     <= sram_dq_in;
                    state     <= DONE;
                    ack       <= 1'b1;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                WR_SETUP: begin
                    state     <= WR_PULSE;
                    sram_we_n <= 1'b0;
                    cnt       <= CNT_W'(WR_WAIT - 1);
                end
                WR_PULSE: if (cnt == '0) begin
                    state     <= WR_HOLD;
                    sram_we_n <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                WR_HOLD: begin
                    state      <= DONE;
                    ack        <= 1'b1;
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nios_system_sram_ctrl.sv
// tb_nios_system_sram_ctrl: vector table, corner sequences and random traffic against a memory/latency reference model
module tb_nios_system_sram_ctrl;
    localparam int ADDR_W = 11, DATA_W = 16, RD_WAIT = 2, WR_WAIT = 2;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out, sram_dq_in;
    logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    nios_system_sram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    nios_system_sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );
    always #5 clk = ~clk;
    // asynchronous SRAM behaviour, plus a back door for preloading contents
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_a = '0;
    logic [DATA_W-1:0] pre_d = '0;
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : '0;
    always @(posedge clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        else if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    end
    typedef struct {
        bit                wr;
        bit                rd;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp;
    } vec_t;
    vec_t vecs [9];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] last_rd = '0;
    int errors = 0, checks = 0;
    int lat, we_lo, oe_lo, dqoe_hi, we_first;
    logic [ADDR_W-1:0] seen_addr;
    logic [DATA_W-1:0] seen_dq, rdat;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_en = 1'b0;
        ref_mem[a] = d;
    endtask
    task automatic access(input bit wr, input bit rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        check("idle_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        bus.address = a; bus.writedata = d; bus.read = rd; bus.write = wr; bus.chipselect = 1'b1;
        lat = 0; we_lo = 0; oe_lo = 0; dqoe_hi = 0; we_first = -1;
        #1;
        while (bus.waitrequest && lat < 64) begin
            @(negedge clk);
            lat++;
            if (!sram_we_n) begin
                we_lo++;
                if (we_first < 0) we_first = lat;
            end
            if (!sram_oe_n) oe_lo++;
            if (sram_dq_oe) dqoe_hi++;
            if (lat == 1) begin
                seen_addr = sram_addr;
                seen_dq = sram_dq_out;
            end
            check("oe_we_excl", 32'(!sram_oe_n && !sram_we_n), 0);
            check("dqoe_vs_oe", 32'(sram_dq_oe && !sram_oe_n), 0);
            #1;
        end
        rdat = bus.readdata;
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    endtask
    task automatic verify(input bit wr, input bit rd, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp);
        access(wr, rd, a, d);
        if (wr) begin
            check("wr_latency", lat, WR_WAIT + 3);
            check("we_cycles", we_lo, WR_WAIT);
            check("we_first", we_first, 2);
            check("dqoe_cycles", dqoe_hi, WR_WAIT + 2);
            check("wr_oe_cycles", oe_lo, 0);
            check("wr_dq_out", seen_dq, d);
            ref_mem[a] = d;
        end else begin
            check("rd_latency", lat, RD_WAIT + 1);
            check("oe_cycles", oe_lo, RD_WAIT);
            check("rd_we_cycles", we_lo, 0);
            check("rd_dqoe_cycles", dqoe_hi, 0);
            last_rd = ref_mem[a];
        end
        check("sram_addr", seen_addr, a);
        check("readdata", rdat, exp);
    endtask
    initial begin
        vecs[0] = '{0, 1, 11'h2A5, 16'h0000, 16'h1234};
        vecs[1] = '{1, 0, 11'h2A5, 16'hBEEF, 16'h1234};
        vecs[2] = '{0, 1, 11'h2A5, 16'h0000, 16'hBEEF};
        vecs[3] = '{1, 0, 11'h7FF, 16'hA5A5, 16'hBEEF};
        vecs[4] = '{0, 1, 11'h7FF, 16'h0000, 16'hA5A5};
        vecs[5] = '{1, 1, 11'h100, 16'h00FF, 16'hA5A5};
        vecs[6] = '{0, 1, 11'h100, 16'h0000, 16'h00FF};
        vecs[7] = '{1, 0, 11'h000, 16'h1111, 16'h00FF};
        vecs[8] = '{0, 1, 11'h000, 16'h0000, 16'h1111};
        bus.address = '0; bus.writedata = '0; bus.read = 1'b0; bus.write = 1'b0; bus.chipselect = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        check("rst_readdata", bus.readdata, 0);
        check("rst_waitreq", bus.waitrequest, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_dq_out", sram_dq_out, 0);
        reset_n = 1'b1;
        preload(11'h2A5, 16'h1234);
        for (int i = 0; i < 16; i++) preload(11'h300 + 11'(i), 16'($urandom));
        for (int i = 0; i < 9; i++) verify(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].exp);
        // master abandons a write after one cycle; the SRAM cycle must still finish
        @(negedge clk);
        bus.address = 11'h060; bus.writedata = 16'h5A5A; bus.write = 1'b1; bus.chipselect = 1'b1;
        @(negedge clk);
        bus.write = 1'b0; bus.chipselect = 1'b0;
        we_lo = 0;
        for (int i = 0; i < 8; i++) begin
            if (!sram_we_n) we_lo++;
            @(negedge clk);
        end
        check("drop_we_cycles", we_lo, WR_WAIT);
        check("drop_waitreq", bus.waitrequest, 0);
        ref_mem[11'h060] = 16'h5A5A;
        verify(0, 1, 11'h060, 16'h0, 16'h5A5A);
        // reset during the write pulse releases the strobes immediately
        @(negedge clk);
        bus.address = 11'h050; bus.writedata = 16'hCAFE; bus.write = 1'b1; bus.chipselect = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_we", sram_we_n, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_we", sram_we_n, 1);
        check("async_rst_dqoe", sram_dq_oe, 0);
        check("async_rst_ce", sram_ce_n, 1);
        check("async_rst_readdata", bus.readdata, 0);
        bus.write = 1'b0; bus.chipselect = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        last_rd = '0;
        verify(0, 1, 11'h300, 16'h0, ref_mem[11'h300]);
        for (int i = 0; i < 40; i++) begin
            automatic logic [ADDR_W-1:0] a = 11'h300 + 11'($urandom_range(0, 15));
            automatic logic [DATA_W-1:0] d = 16'($urandom);
            automatic int op = $urandom_range(0, 4);
            automatic bit wr = (op >= 3);
            automatic bit rd = (op != 3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            verify(wr, rd, a, d, wr ? last_rd : ref_mem[a]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nios_system_sram_ctrl.md
Name: nios_system_sram_ctrl

Overview:
- Avalon-MM slave that sequences single-word reads and writes to an external asynchronous SRAM.
- Generates the SRAM chip-enable, output-enable and write-enable strobes with programmable wait states.
- Stalls the Nios master through waitrequest until each access completes.
- Sits between the system interconnect and the SRAM pins, alongside the existing sram address/data PIO blocks.

Parameters:
- ADDR_W, 11, SRAM word-address width.
- DATA_W, 16, SRAM data width; also the width of writedata and readdata.
- RD_WAIT, 2, cycles oe_n is held low before read data is sampled; minimum 1.
- WR_WAIT, 2, cycles we_n is held low per write; minimum 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  word address from the master.
- chipselect  in  1  slave select.
- read  in  1  read request, qualified by chipselect.
- write  in  1  write request, qualified by chipselect.
- writedata  in  DATA_W  write data.
- readdata  out  DATA_W  read data; valid in the cycle waitrequest is low for a read.
- waitrequest  out  1  stall to the master.
- sram_addr  out  ADDR_W  SRAM address pins.
- sram_dq_out  out  DATA_W  data driven to the SRAM.
- sram_dq_oe  out  1  tristate enable for sram_dq_out.
- sram_dq_in  in  DATA_W  data returned by the SRAM.
- sram_ce_n  out  1  SRAM chip enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- All SRAM outputs and readdata are registered. waitrequest = chipselect & (read | write) & ~ack, where ack is a registered flag high only in state DONE.
- Reset (async, any state):
  - state = IDLE, ack = 0.
  - sram_ce_n = sram_oe_n = sram_we_n = 1, sram_dq_oe = 0.
  - sram_addr = 0, sram_dq_out = 0, readdata = 0.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A wait counter counts down RD_WAIT-1 or WR_WAIT-1.
- IDLE: all strobes high, dq_oe = 0. On chipselect & (read | write):
  - Latch address into sram_addr and writedata into sram_dq_out.
  - Go to WR_SETUP if write is set (write wins if read and write are both set), else RD.
- RD, RD_WAIT cycles:
  - ce_n = 0, oe_n = 0, we_n = 1, dq_oe = 0.
  - On the last RD cycle, readdata <= sram_dq_in, then go to DONE.
- WR_SETUP, 1 cycle: ce_n = 0, we_n = 1, oe_n = 1, dq_oe = 1 (address and data setup).
- WR_PULSE, WR_WAIT cycles: we_n = 0, ce_n = 0, dq_oe = 1.
- WR_HOLD, 1 cycle: we_n = 1, ce_n = 0, dq_oe = 1 (data hold). Then go to DONE.
- DONE, 1 cycle:
  - All strobes high, dq_oe = 0, ack = 1 (waitrequest low, so the master completes).
  - Next state is IDLE. This gives at least one dead bus cycle between any two accesses (bus turnaround).
- Latency, with the request first seen in cycle T:
  - Read: waitrequest low in cycle T+RD_WAIT+1.
  - Write: waitrequest low in cycle T+WR_WAIT+3.
  - Back-to-back accesses: the next request is accepted in the IDLE cycle following DONE.
- readdata holds its value until the next read sample; writes do not alter it.
- If the master drops the request mid-access, the controller still completes the SRAM cycle; ack is raised and ignored.
- No new request is accepted outside IDLE.
- sram_oe_n and sram_we_n are never low in the same cycle. sram_dq_oe is never high while sram_oe_n is low.
- Reset asserted mid-write: we_n and dq_oe are released immediately (asynchronously). The SRAM word contents are then undefined.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles -> ce_n/oe_n/we_n = 1, dq_oe = 0, readdata = 0, waitrequest = 0 with chipselect low.
- Single write (defaults): address = 0x2A5, writedata = 0xBEEF, write = 1 at T -> sram_addr = 0x2A5, dq_out = 0xBEEF, dq_oe = 1 during T+1..T+4; we_n low exactly at T+2..T+3; waitrequest low at T+5 only.
- Single read: SRAM model returns 0x1234 at 0x2A5, read = 1 at T -> oe_n low at T+1..T+2; readdata = 0x1234 with waitrequest low at T+3; dq_oe stays 0 throughout.
- Back-to-back write then read to address 0x7FF (max address) -> exactly one idle cycle with all strobes high between the accesses; read returns the written data. No cycle has oe_n and we_n both low.
- Simultaneous read = write = 1, writedata = 0x00FF -> a write cycle is performed; a later read of the same address returns 0x00FF.
- Reset pulse during WR_PULSE -> we_n = 1 and dq_oe = 0 in the same cycle (async). State returns to IDLE; the next read completes with normal latency.
